wb_arbiter2: RTL and testbench

- Two-master, one-slave pipelined Wishbone arbiter sharing one memory-side bus.
- Typical use: master 0 is the cache's refill/writeback bus (cache outbus), master 1 is the uncached data bus. The shared slave is the external memory bus.
- Round-robin grant; the grant is held for the whole bus cycle (cyc).
- Counts outstanding pipelined requests so the grant never moves while acks are still owed.

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/if_wb.sv | 22 ++
 rtl/wb_arbiter2.sv | 146 ++++++++++++++
 tb/tb_wb_arbiter2.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-master Wishbone arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // One-hot grant vector for a given arbiter state.
    function automatic logic [1:0] grant_of(arb_state_t s);
        case (s)
            OWN0:    grant_of = GRANT_M0;
            OWN1:    grant_of = GRANT_M1;
            default: grant_of = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/if_wb.sv
// rtl/if_wb.sv - pipelined Wishbone bus bundle with master/slave views
interface if_wb;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        stall;

    modport master (
        output adr, dat_m, sel, cyc, stb, we,
        input  dat_s, ack, stall
    );

    modport slave (
        input  adr, dat_m, sel, cyc, stb, we,
        output dat_s, ack, stall
    );
endinterface

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - round-robin two-master pipelined Wishbone arbiter
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int MAXOUT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        m0,
    if_wb.slave        m1,
    if_wb.master       outbus,
    output logic [1:0] grant
);

    localparam int CNTW = $clog2(MAXOUT + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAXOUT);

    arb_state_t      state;
    logic            last;
    logic [CNTW-1:0] outstanding;

    logic            full;
    logic            busy;
    logic            accept;

    logic [31:0]     bus_adr;
    logic [31:0]     bus_dat_m;
    logic [3:0]      bus_sel;
    logic            bus_we;
    logic            bus_cyc;
    logic            bus_stb;

    logic [31:0]     m0_dat_s;
    logic            m0_ack;
    logic            m0_stall;
    logic [31:0]     m1_dat_s;
    logic            m1_ack;
    logic            m1_stall;

    assign full   = (outstanding == CNT_MAX);
    assign busy   = (outstanding != '0);
    assign accept = bus_stb & ~outbus.stall;

    // Owner's bus is passed straight through; cyc is held while acks are
    // still owed even if the owner has already dropped it.
    always_comb begin
        bus_adr   = '0;
        bus_dat_m = '0;
        bus_sel   = '0;
        bus_we    = 1'b0;
        bus_cyc   = 1'b0;
        bus_stb   = 1'b0;
        m0_dat_s  = '0;
        m0_ack    = 1'b0;
        m0_stall  = 1'b1;
        m1_dat_s  = '0;
        m1_ack    = 1'b0;
        m1_stall  = 1'b1;
        case (state)
            OWN0: begin
                bus_adr   = m0.adr;
                bus_dat_m = m0.dat_m;
                bus_sel   = m0.sel;
                bus_we    = m0.we;
                bus_cyc   = m0.cyc | busy;
                bus_stb   = m0.cyc & m0.stb & ~full;
                m0_dat_s  = outbus.dat_s;
                m0_ack    = outbus.ack;
                m0_stall  = outbus.stall | full;
            end
            OWN1: begin
                bus_adr   = m1.adr;
                bus_dat_m = m1.dat_m;
                bus_sel   = m1.sel;
                bus_we    = m1.we;
                bus_cyc   = m1.cyc | busy;
                bus_stb   = m1.cyc & m1.stb & ~full;
                m1_dat_s  = outbus.dat_s;
                m1_ack    = outbus.ack;
                m1_stall  = outbus.stall | full;
            end
            default: ;
        endcase
    end

    assign outbus.adr   = bus_adr;
    assign outbus.dat_m = bus_dat_m;
    assign outbus.sel   = bus_sel;
    assign outbus.we    = bus_we;
    assign outbus.cyc   = bus_cyc;
    assign outbus.stb   = bus_stb;

    assign m0.dat_s = m0_dat_s;
    assign m0.ack   = m0_ack;
    assign m0.stall = m0_stall;
    assign m1.dat_s = m1_dat_s;
    assign m1.ack   = m1_ack;
    assign m1.stall = m1_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            grant       <= GRANT_NONE;
            last        <= 1'b1;
            outstanding <= '0;
        end else begin
            // A stray ack with nothing outstanding is forwarded but not counted.
            if (accept && !outbus.ack) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && outbus.ack && busy) begin
                outstanding <= outstanding - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (m0.cyc && (!m1.cyc || last)) begin
                        state <= OWN0;
                        grant <= grant_of(OWN0);
                    end else if (m1.cyc && (!m0.cyc || !last)) begin
                        state <= OWN1;
                        grant <= grant_of(OWN1);
                    end
                end
                OWN0: begin
                    if (!m0.cyc && !busy) begin
                        state <= IDLE;
                        grant <= GRANT_NONE;
                        last  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1.cyc && !busy) begin
                        state <= IDLE;
                        grant <= GRANT_NONE;
                        last  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= GRANT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - directed self-checking bench for wb_arbiter2
module tb_wb_arbiter2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;
    int         checks = 0;
    int         errors = 0;

    if_wb m0_bus ();
    if_wb m1_bus ();
    if_wb mem_bus ();

    wb_arbiter2 #(.MAXOUT(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .m0     (m0_bus),
        .m1     (m1_bus),
        .outbus (mem_bus),
        .grant  (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        m0_bus.adr = '0; m0_bus.dat_m = '0; m0_bus.sel = '0;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
        m1_bus.adr = '0; m1_bus.dat_m = '0; m1_bus.sel = '0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
        mem_bus.dat_s = '0; mem_bus.ack = 1'b0; mem_bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b expected 00", grant); end
        checks++; if (mem_bus.cyc !== 1'b0 || mem_bus.stb !== 1'b0) begin errors++; $display("FAIL rst_bus: cyc=%b stb=%b expected 0 0", mem_bus.cyc, mem_bus.stb); end
        checks++; if (m0_bus.stall !== 1'b1 || m1_bus.stall !== 1'b1) begin errors++; $display("FAIL rst_stall: m0=%b m1=%b expected 1 1", m0_bus.stall, m1_bus.stall); end
        checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", dut.outstanding); end
        rst = 1'b0;
    endtask

    task automatic test_tie();
        @(negedge clk); m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_first: got %b expected 01", grant); end
        m0_bus.cyc = 1'b0;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00 || mem_bus.cyc !== 1'b0) begin errors++; $display("FAIL tie_gap: grant=%b cyc=%b expected 00 0", grant, mem_bus.cyc); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_second: got %b expected 10", grant); end
        m1_bus.cyc = 1'b0;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_release: got %b expected 00", grant); end
        m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_repeat: got %b expected 01", grant); end
        m0_bus.cyc = 1'b0; m1_bus.cyc = 1'b0;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_end: got %b expected 00", grant); end
    endtask

    task automatic test_single_master();
        int  acks = 0;
        logic m1_stalled = 1'b1;
        @(negedge clk); m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h100; #1;
        checks++; if (mem_bus.cyc !== 1'b0) begin errors++; $display("FAIL sm_cyc_delay: got %b expected 0", mem_bus.cyc); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01 || mem_bus.cyc !== 1'b1 || mem_bus.stb !== 1'b1) begin errors++; $display("FAIL sm_grant: grant=%b cyc=%b stb=%b expected 01 1 1", grant, mem_bus.cyc, mem_bus.stb); end
        checks++; if (mem_bus.adr !== 32'h100) begin errors++; $display("FAIL sm_adr: got %h expected 00000100", mem_bus.adr); end
        m1_stalled &= m1_bus.stall;
        @(negedge clk); m0_bus.adr = 32'h104; #1;
        checks++; if (dut.outstanding !== 3'd1) begin errors++; $display("FAIL sm_cnt1: got %0d expected 1", dut.outstanding); end
        m1_stalled &= m1_bus.stall;
        @(negedge clk); m0_bus.adr = 32'h108; mem_bus.ack = 1'b1; mem_bus.dat_s = 32'hA0A0_0000; #1;
        if (m0_bus.ack) acks++;
        checks++; if (m0_bus.dat_s !== 32'hA0A0_0000) begin errors++; $display("FAIL sm_dat_s: got %h expected a0a00000", m0_bus.dat_s); end
        m1_stalled &= m1_bus.stall;
        @(negedge clk); m0_bus.stb = 1'b0; mem_bus.dat_s = 32'hA0A0_0001; #1;
        if (m0_bus.ack) acks++;
        m1_stalled &= m1_bus.stall;
        @(negedge clk); mem_bus.dat_s = 32'hA0A0_0002; #1;
        if (m0_bus.ack) acks++;
        m1_stalled &= m1_bus.stall;
        @(negedge clk); mem_bus.ack = 1'b0; m0_bus.cyc = 1'b0; #1;
        m1_stalled &= m1_bus.stall;
        checks++; if (acks != 3) begin errors++; $display("FAIL sm_acks: got %0d expected 3", acks); end
        checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL sm_cnt_end: got %0d expected 0", dut.outstanding); end
        checks++; if (m1_stalled !== 1'b1) begin errors++; $display("FAIL sm_m1_stall: got %b expected 1", m1_stalled); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sm_release: got %b expected 00", grant); end
    endtask

    task automatic test_maxout();
        int accepts = 0;
        @(negedge clk); m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 32'h400;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (mem_bus.stb && !mem_bus.stall) accepts++;
            if (i >= 4) begin
                checks++; if (m1_bus.stall !== 1'b1) begin errors++; $display("FAIL mx_stall_%0d: got %b expected 1", i, m1_bus.stall); end
            end
            @(negedge clk);
        end
        checks++; if (accepts != 4) begin errors++; $display("FAIL mx_accepts: got %0d expected 4", accepts); end
        checks++; if (dut.outstanding !== 3'd4) begin errors++; $display("FAIL mx_cnt_full: got %0d expected 4", dut.outstanding); end
        mem_bus.ack = 1'b1; #1;
        checks++; if (mem_bus.stb !== 1'b0 || m1_bus.ack !== 1'b1) begin errors++; $display("FAIL mx_ack_cycle: stb=%b ack=%b expected 0 1", mem_bus.stb, m1_bus.ack); end
        @(negedge clk); mem_bus.ack = 1'b0; #1;
        checks++; if (mem_bus.stb !== 1'b1 || m1_bus.stall !== 1'b0) begin errors++; $display("FAIL mx_fifth: stb=%b stall=%b expected 1 0", mem_bus.stb, m1_bus.stall); end
        @(negedge clk); m1_bus.stb = 1'b0; mem_bus.ack = 1'b1;
        repeat (4) @(negedge clk);
        mem_bus.ack = 1'b0; m1_bus.cyc = 1'b0; #1;
        checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL mx_drain: got %0d expected 0", dut.outstanding); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mx_release: got %b expected 00", grant); end
    endtask

    task automatic test_early_drop();
        @(negedge clk); m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h200;
        @(negedge clk);
        @(negedge clk); m0_bus.adr = 32'h204;
        @(negedge clk); m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m1_bus.cyc = 1'b1; #1;
        checks++; if (mem_bus.cyc !== 1'b1 || mem_bus.stb !== 1'b0) begin errors++; $display("FAIL ed_hold: cyc=%b stb=%b expected 1 0", mem_bus.cyc, mem_bus.stb); end
        checks++; if (grant !== 2'b01 || m1_bus.stall !== 1'b1) begin errors++; $display("FAIL ed_grant: grant=%b m1_stall=%b expected 01 1", grant, m1_bus.stall); end
        @(negedge clk); mem_bus.ack = 1'b1; mem_bus.dat_s = 32'h5555_0001; #1;
        checks++; if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0 || m0_bus.dat_s !== 32'h5555_0001) begin errors++; $display("FAIL ed_ack1: m0=%b m1=%b dat=%h expected 1 0 55550001", m0_bus.ack, m1_bus.ack, m0_bus.dat_s); end
        @(negedge clk); mem_bus.dat_s = 32'h5555_0002; #1;
        checks++; if (m0_bus.ack !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL ed_ack2: ack=%b grant=%b expected 1 01", m0_bus.ack, grant); end
        @(negedge clk); mem_bus.ack = 1'b0; #1;
        checks++; if (grant !== 2'b01 || dut.outstanding !== 3'd0 || mem_bus.cyc !== 1'b0) begin errors++; $display("FAIL ed_zero: grant=%b cnt=%0d cyc=%b expected 01 0 0", grant, dut.outstanding, mem_bus.cyc); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ed_gap: got %b expected 00", grant); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ed_m1: got %b expected 10", grant); end
        m1_bus.cyc = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_slave_stall();
        @(negedge clk);
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.we = 1'b1; m0_bus.sel = 4'hF;
        m0_bus.adr = 32'h300; m0_bus.dat_m = 32'hDEAD_BEEF; mem_bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (m0_bus.stall !== 1'b1 || dut.outstanding !== 3'd0) begin errors++; $display("FAIL ss_stall_%0d: stall=%b cnt=%0d expected 1 0", i, m0_bus.stall, dut.outstanding); end
            checks++; if (mem_bus.adr !== 32'h300 || mem_bus.dat_m !== 32'hDEAD_BEEF || mem_bus.we !== 1'b1) begin errors++; $display("FAIL ss_hold_%0d: adr=%h dat=%h we=%b expected 00000300 deadbeef 1", i, mem_bus.adr, mem_bus.dat_m, mem_bus.we); end
        end
        @(negedge clk); mem_bus.stall = 1'b0; #1;
        checks++; if (m0_bus.stall !== 1'b0) begin errors++; $display("FAIL ss_release: got %b expected 0", m0_bus.stall); end
        @(negedge clk); m0_bus.stb = 1'b0; mem_bus.ack = 1'b1; #1;
        checks++; if (dut.outstanding !== 3'd1) begin errors++; $display("FAIL ss_cnt: got %0d expected 1", dut.outstanding); end
        @(negedge clk); mem_bus.ack = 1'b0; m0_bus.cyc = 1'b0; m0_bus.we = 1'b0;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ss_end: got %b expected 00", grant); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 32'h500;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); m1_bus.stb = 1'b0; #1;
        checks++; if (dut.outstanding !== 3'd2 || grant !== 2'b10 || mem_bus.cyc !== 1'b1) begin errors++; $display("FAIL ar_pre: cnt=%0d grant=%b cyc=%b expected 2 10 1", dut.outstanding, grant, mem_bus.cyc); end
        #2; rst = 1'b1; m0_bus.cyc = 1'b1; #1;
        checks++; if (mem_bus.cyc !== 1'b0 || grant !== 2'b00 || dut.outstanding !== 3'd0) begin errors++; $display("FAIL ar_async: cyc=%b grant=%b cnt=%0d expected 0 00 0", mem_bus.cyc, grant, dut.outstanding); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ar_tie: got %b expected 01", grant); end
        drive_idle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_master();
        test_maxout();
        test_early_drop();
        test_slave_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
